// File: rtl/cpu_pkg.sv
// Shared CPU definitions: front-end state encoding and the default widths
// used by fetch, decode and the instruction ROM.
package cpu_pkg;

    // Program counter / instruction ROM address width.
    localparam int PC_W = 10;

    // Instruction word width.
    localparam int INSTR_W = 9;

    // Encoding that ends a program.
    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

    // Width of the run-cycle counter.
    localparam int CNT_W = 16;

    // Run-control states of the fetch unit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : cpu_pkg

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: the host run handshake, datapath control, ROM port and the
// instruction stream presented to decode.
interface instr_fetch_if #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int CNT_W   = cpu_pkg::CNT_W
);

    // Host run handshake.
    logic               Start;
    logic               Ack;
    logic [CNT_W-1:0]   Run_Cycles;

    // Datapath control.
    logic               Stall;
    logic               Branch_En;
    logic [PC_W-1:0]    Branch_Tgt;

    // Instruction ROM port.
    logic [PC_W-1:0]    Instr_Addr;
    logic [INSTR_W-1:0] Instr_Rd_Data;

    // Instruction stream to decode.
    logic [INSTR_W-1:0] Instr;
    logic [PC_W-1:0]    Instr_PC;
    logic               Instr_Valid;

    // The fetch unit itself.
    modport master (
        input  Start, Stall, Branch_En, Branch_Tgt, Instr_Rd_Data,
        output Ack, Run_Cycles, Instr_Addr, Instr, Instr_PC, Instr_Valid
    );

    // Everything around it: host, datapath and ROM.
    modport slave (
        output Start, Stall, Branch_En, Branch_Tgt, Instr_Rd_Data,
        input  Ack, Run_Cycles, Instr_Addr, Instr, Instr_PC, Instr_Valid
    );

endinterface : instr_fetch_if

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Clear wins over enable, and
// the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, else increment unless already saturated.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/instr_fetch.sv
// Instruction fetch front end. Owns the PC, addresses a registered ROM with
// next-PC so the word for the new PC arrives together with it (zero-bubble
// branches), and runs the Start/Ack handshake: IDLE until Start, RUN until the
// halt instruction retires, DONE with Ack up until Start drops.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                 PC_W       = cpu_pkg::PC_W,
    parameter int                 INSTR_W    = cpu_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0] HALT_INSTR = cpu_pkg::HALT_INSTR,
    parameter int                 CNT_W      = cpu_pkg::CNT_W
) (
    input  logic          Clk,
    input  logic          Reset,
    instr_fetch_if.master bus
);

    state_e          state_q;
    state_e          state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;      // next_pc; also drives the ROM address
    logic            valid_q;
    logic            valid_d;
    logic            ack_q;
    logic            ack_d;
    logic            cnt_clr;
    logic            cnt_en;
    logic            halt_seen;

    // The presented word is mem[pc_q]; in RUN it is always live.
    assign halt_seen = (bus.Instr_Rd_Data == HALT_INSTR);

    // Next state, next PC and next registered outputs.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                pc_d    = '0;
                valid_d = 1'b0;
                ack_d   = 1'b0;
                if (bus.Start) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    cnt_clr = 1'b1;
                end
            end

            RUN: begin
                valid_d = 1'b1;
                cnt_en  = 1'b1;
                if (bus.Stall) begin
                    // Stall beats branch and halt: hold the current instruction.
                    pc_d = pc_q;
                end else if (halt_seen) begin
                    // Halt retires: PC freezes on the halt address, any branch is dropped.
                    pc_d    = pc_q;
                    state_d = DONE;
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                end else if (bus.Branch_En && valid_q) begin
                    pc_d = bus.Branch_Tgt;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end

            DONE: begin
                pc_d    = pc_q;
                valid_d = 1'b0;
                ack_d   = 1'b1;
                // Only a dropped Start re-arms; a held Start never restarts.
                if (!bus.Start) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                pc_d    = '0;
                valid_d = 1'b0;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Run-control FSM with registered PC, Valid and Ack.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    // Cycles spent in RUN, cleared on each new program and frozen afterwards.
    sat_counter #(
        .W (CNT_W)
    ) u_run_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (bus.Run_Cycles)
    );

    assign bus.Instr_Addr  = pc_d;
    assign bus.Instr       = bus.Instr_Rd_Data;
    assign bus.Instr_PC    = pc_q;
    assign bus.Instr_Valid = valid_q;
    assign bus.Ack         = ack_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: basic run, branch, stall, PC wrap,
// halt at address 0 and reset in the middle of a run.
module tb_instr_fetch;

    logic Clk;
    logic Reset;

    instr_fetch_if bus ();

    instr_fetch dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // Registered instruction ROM model: returns rom[addr] one cycle later.
    logic [8:0] rom [0:1023];

    always @(posedge Clk) begin
        bus.Instr_Rd_Data <= rom[bus.Instr_Addr];
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [9:0] pc,
                              input logic valid, input logic ack);
        check({tag, " pc"},    32'(bus.Instr_PC),    32'(pc));
        check({tag, " valid"}, 32'(bus.Instr_Valid), 32'(valid));
        check({tag, " ack"},   32'(bus.Ack),         32'(ack));
    endtask

    // Non-halt filler: word i holds the low byte of i.
    task automatic fill_rom();
        for (int i = 0; i < 1024; i++) begin
            rom[i] = {1'b0, 8'(i)};
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation timed out");
    end

    initial begin
        Reset          = 1'b1;
        bus.Start      = 1'b0;
        bus.Stall      = 1'b0;
        bus.Branch_En  = 1'b0;
        bus.Branch_Tgt = '0;
        fill_rom();

        // ---------------- reset state ----------------
        #2 Reset = 1'b0;
        #1;
        expect_out("rst", 10'h000, 1'b0, 1'b0);
        check("rst cycles", 32'(bus.Run_Cycles), 32'd0);
        check("rst addr",   32'(bus.Instr_Addr), 32'd0);
        step();
        step();
        Reset = 1'b1;
        step();

        // ---------------- basic 3-instruction program ----------------
        rom[0] = 9'h001;
        rom[1] = 9'h002;
        rom[2] = 9'h1FF;
        bus.Start = 1'b1;
        step();
        expect_out("t1 i0", 10'h000, 1'b1, 1'b0);
        check("t1 i0 instr",  32'(bus.Instr),      32'h001);
        check("t1 i0 cycles", 32'(bus.Run_Cycles), 32'd0);
        step();
        expect_out("t1 i1", 10'h001, 1'b1, 1'b0);
        check("t1 i1 instr", 32'(bus.Instr), 32'h002);
        step();
        expect_out("t1 i2", 10'h002, 1'b1, 1'b0);
        check("t1 i2 instr", 32'(bus.Instr), 32'h1FF);
        step();
        expect_out("t1 done", 10'h002, 1'b0, 1'b1);
        check("t1 done cycles", 32'(bus.Run_Cycles), 32'd3);
        // Start held: stay in DONE, no refetch.
        step();
        step();
        expect_out("t1 hold", 10'h002, 1'b0, 1'b1);
        check("t1 hold cycles", 32'(bus.Run_Cycles), 32'd3);
        check("t1 hold addr",   32'(bus.Instr_Addr), 32'h002);
        bus.Start = 1'b0;
        step();
        check("t1 idle ack",    32'(bus.Ack),         32'd0);
        check("t1 idle valid",  32'(bus.Instr_Valid), 32'd0);
        check("t1 idle addr",   32'(bus.Instr_Addr),  32'd0);
        check("t1 idle cycles", 32'(bus.Run_Cycles),  32'd3);
        step();

        // ---------------- zero-bubble branch ----------------
        fill_rom();
        rom[10'h042] = 9'h1FF;
        bus.Start = 1'b1;
        step();
        check("t2 cycles clr", 32'(bus.Run_Cycles), 32'd0);
        step();
        step();
        step();
        expect_out("t2 pc3", 10'h003, 1'b1, 1'b0);
        bus.Branch_En  = 1'b1;
        bus.Branch_Tgt = 10'h040;
        #1;
        check("t2 br addr", 32'(bus.Instr_Addr), 32'h040);
        step();
        bus.Branch_En = 1'b0;
        expect_out("t2 tgt", 10'h040, 1'b1, 1'b0);
        check("t2 tgt instr", 32'(bus.Instr), 32'h040);
        step();
        expect_out("t2 tgt+1", 10'h041, 1'b1, 1'b0);
        check("t2 tgt+1 instr", 32'(bus.Instr), 32'h041);
        step();
        step();
        expect_out("t2 done", 10'h042, 1'b0, 1'b1);
        check("t2 cycles", 32'(bus.Run_Cycles), 32'd7);
        bus.Start = 1'b0;
        step();
        step();

        // ---------------- stall beats branch ----------------
        fill_rom();
        rom[9] = 9'h1FF;
        bus.Start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
        end
        expect_out("t3 pc7", 10'h007, 1'b1, 1'b0);
        bus.Stall      = 1'b1;
        bus.Branch_En  = 1'b1;
        bus.Branch_Tgt = 10'h100;
        #1;
        check("t3 stall addr", 32'(bus.Instr_Addr), 32'h007);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("t3 stall%0d", i), 10'h007, 1'b1, 1'b0);
            check($sformatf("t3 stall%0d instr", i), 32'(bus.Instr), 32'h007);
        end
        bus.Stall     = 1'b0;
        bus.Branch_En = 1'b0;
        step();
        expect_out("t3 pc8", 10'h008, 1'b1, 1'b0);
        step();
        step();
        expect_out("t3 done", 10'h009, 1'b0, 1'b1);
        check("t3 cycles", 32'(bus.Run_Cycles), 32'd13);
        bus.Start = 1'b0;
        step();
        step();

        // ---------------- halt at address 0 ----------------
        fill_rom();
        rom[0] = 9'h1FF;
        bus.Start = 1'b1;
        step();
        expect_out("t4 halt0", 10'h000, 1'b1, 1'b0);
        step();
        expect_out("t4 done", 10'h000, 1'b0, 1'b1);
        check("t4 cycles", 32'(bus.Run_Cycles), 32'd1);
        bus.Start = 1'b0;
        step();
        step();

        // ---------------- PC wrap 0x3FF -> 0x000 ----------------
        fill_rom();
        rom[0]       = 9'h010;
        rom[10'h3FF] = 9'h0AA;
        bus.Start = 1'b1;
        step();
        step();
        expect_out("t5 pc1", 10'h001, 1'b1, 1'b0);
        rom[0] = 9'h1FF;
        bus.Branch_En  = 1'b1;
        bus.Branch_Tgt = 10'h3FF;
        step();
        bus.Branch_En = 1'b0;
        expect_out("t5 max", 10'h3FF, 1'b1, 1'b0);
        check("t5 max instr", 32'(bus.Instr), 32'h0AA);
        step();
        expect_out("t5 wrap", 10'h000, 1'b1, 1'b0);
        check("t5 wrap instr", 32'(bus.Instr), 32'h1FF);
        step();
        expect_out("t5 done", 10'h000, 1'b0, 1'b1);
        check("t5 cycles", 32'(bus.Run_Cycles), 32'd4);
        bus.Start = 1'b0;
        step();
        step();

        // ---------------- reset mid-run ----------------
        fill_rom();
        rom[20] = 9'h1FF;
        bus.Start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
        end
        expect_out("t6 pc5", 10'h005, 1'b1, 1'b0);
        Reset = 1'b0;
        #1;
        expect_out("t6 rst", 10'h000, 1'b0, 1'b0);
        check("t6 rst cycles", 32'(bus.Run_Cycles), 32'd0);
        check("t6 rst addr",   32'(bus.Instr_Addr), 32'd0);
        step();
        Reset = 1'b1;
        step();
        expect_out("t6 rerun", 10'h000, 1'b1, 1'b0);
        check("t6 rerun instr", 32'(bus.Instr), 32'h000);
        step();
        expect_out("t6 rerun1", 10'h001, 1'b1, 1'b0);
        check("t6 rerun cycles", 32'(bus.Run_Cycles), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch
